// File: rtl/blake2_bus_host_pkg.sv
// Shared definitions for the BLAKE2 bus host: FSM states, beat-type encodings
// and the block / config framing sizes.
package blake2_bus_host_pkg;

    localparam int unsigned BLOCK_BYTES = 64;
    localparam int unsigned CFG_BEATS   = 4;

    typedef enum logic [2:0] {
        StIdle,
        StCfg,
        StData,
        StWaitHash,
        StRxHash,
        StDone,
        StErr
    } state_e;

    // data_ctrl_o[2:1] beat type
    typedef enum logic [1:0] {
        BeatCfg  = 2'b00,
        BeatData = 2'b01,
        BeatLast = 2'b10,
        BeatRsvd = 2'b11
    } beat_e;

endpackage

// File: rtl/bus_sync2.sv
// Two-flop synchronizer for a bus of Width bits.
// Ports: clk, rst_async (async active-high), d_i (raw input), q_o (synchronized).
module bus_sync2 #(
    parameter int unsigned Width = 10
) (
    input  logic             clk,
    input  logic             rst_async,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] meta_q;
    logic [Width-1:0] sync_q;

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/blake2_bus_host.sv
// Host-side sequencer for a BLAKE2 core on a byte bus: sends 4 config beats,
// streams the message padded to 64-byte blocks, then collects nn digest bytes.
// Ports: start_i/kk_i/nn_i/ll_i job request; msg_* message stream in;
// data_o/data_ctrl_o beats to the core; hash_i/hash_ctrl_i digest and ready from
// the core; hash_*_o digest stream out; busy_o/done_o/error_o status;
// loopback_i/loopback_ctrl_o registered loopback request.
module blake2_bus_host
    import blake2_bus_host_pkg::*;
#(
    parameter int unsigned PMOD_W         = 8,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic              clk,
    input  logic              rst_async,
    input  logic              start_i,
    input  logic [7:0]        kk_i,
    input  logic [7:0]        nn_i,
    input  logic [15:0]       ll_i,
    input  logic [PMOD_W-1:0] msg_data_i,
    input  logic              msg_valid_i,
    output logic              msg_ready_o,
    output logic [PMOD_W-1:0] data_o,
    output logic [2:0]        data_ctrl_o,
    output logic [1:0]        loopback_ctrl_o,
    input  logic [1:0]        loopback_i,
    input  logic [PMOD_W-1:0] hash_i,
    input  logic [1:0]        hash_ctrl_i,
    output logic [PMOD_W-1:0] hash_data_o,
    output logic              hash_valid_o,
    output logic              hash_last_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o
);

    logic [PMOD_W+1:0] sync_s;
    logic              ready_s;
    logic              hvalid_s;
    logic [PMOD_W-1:0] hash_s;

    bus_sync2 #(
        .Width(PMOD_W + 2)
    ) u_sync (
        .clk      (clk),
        .rst_async(rst_async),
        .d_i      ({hash_ctrl_i, hash_i}),
        .q_o      (sync_s)
    );

    assign hash_s   = sync_s[PMOD_W-1:0];
    assign ready_s  = sync_s[PMOD_W];
    assign hvalid_s = sync_s[PMOD_W+1];

    state_e            state_q, state_d;
    logic [7:0]        kk_q, kk_d, nn_q, nn_d;
    logic [15:0]       ll_q, ll_d;
    logic [1:0]        cfg_idx_q, cfg_idx_d;
    logic [15:0]       byte_cnt_q, byte_cnt_d;  // block byte index, then digest byte count
    logic [15:0]       blk_cnt_q, blk_cnt_d;
    logic [31:0]       wait_cnt_q, wait_cnt_d;
    logic [PMOD_W-1:0] data_q, data_d, hash_data_q, hash_data_d;
    logic [2:0]        data_ctrl_q, data_ctrl_d;
    logic [1:0]        loopback_q;
    logic              hash_valid_q, hash_valid_d, hash_last_q, hash_last_d;
    logic              busy_q, busy_d, done_q, done_d, error_q, error_d;

    logic [21:0]       msg_idx;
    logic              owed;
    logic [15:0]       last_blk;
    logic              is_last_blk;
    logic [7:0]        cfg_byte;
    logic              fwd;

    // Absolute message index of the current block byte; bytes at or past ll are padding.
    assign msg_idx     = {blk_cnt_q, 6'd0} + {6'd0, byte_cnt_q};
    assign owed        = msg_idx < {6'd0, ll_q};
    // An empty message still produces one (all-padding) block.
    assign last_blk    = (ll_q == 16'd0) ? 16'd0 : ((ll_q - 16'd1) >> 6);
    assign is_last_blk = blk_cnt_q == last_blk;

    always_comb begin
        cfg_byte = kk_q;
        case (cfg_idx_q)
            2'd0:    cfg_byte = kk_q;
            2'd1:    cfg_byte = nn_q;
            2'd2:    cfg_byte = ll_q[7:0];
            default: cfg_byte = ll_q[15:8];
        endcase
    end

    always_comb begin
        state_d      = state_q;
        kk_d         = kk_q;
        nn_d         = nn_q;
        ll_d         = ll_q;
        cfg_idx_d    = cfg_idx_q;
        byte_cnt_d   = byte_cnt_q;
        blk_cnt_d    = blk_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        data_d       = '0;
        data_ctrl_d  = 3'b000;
        hash_data_d  = '0;
        hash_valid_d = 1'b0;
        hash_last_d  = 1'b0;
        error_d      = error_q;
        fwd          = 1'b0;

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d    = StCfg;
                    kk_d       = kk_i;
                    nn_d       = nn_i;
                    ll_d       = ll_i;
                    cfg_idx_d  = 2'd0;
                    byte_cnt_d = '0;
                    blk_cnt_d  = '0;
                    error_d    = 1'b0;
                end
            end
            StCfg: begin
                if (ready_s) begin
                    data_d      = PMOD_W'(cfg_byte);
                    data_ctrl_d = {BeatCfg, 1'b1};
                    cfg_idx_d   = cfg_idx_q + 2'd1;
                    if (cfg_idx_q == 2'(CFG_BEATS - 1)) begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                // Stall (no beat) while a real message byte is owed but not offered.
                if (ready_s && (!owed || msg_valid_i)) begin
                    data_d      = owed ? msg_data_i : '0;
                    data_ctrl_d = {(is_last_blk ? BeatLast : BeatData), 1'b1};
                    if (byte_cnt_q == 16'(BLOCK_BYTES - 1)) begin
                        byte_cnt_d = '0;
                        blk_cnt_d  = blk_cnt_q + 16'd1;
                        if (is_last_blk) begin
                            state_d    = StWaitHash;
                            wait_cnt_d = '0;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + 16'd1;
                    end
                end
            end
            StWaitHash: begin
                if (hvalid_s) begin
                    fwd = 1'b1;
                end else if (wait_cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
                    state_d = StErr;
                    error_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 32'd1;
                end
            end
            StRxHash: begin
                if (hvalid_s) begin
                    fwd = 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // The first digest byte is the one that ends WAIT_HASH, so it is forwarded too.
        if (fwd) begin
            hash_data_d  = hash_s;
            hash_valid_d = 1'b1;
            byte_cnt_d   = byte_cnt_q + 16'd1;
            if (byte_cnt_q + 16'd1 == {8'd0, nn_q}) begin
                hash_last_d = 1'b1;
                state_d     = StDone;
            end else begin
                state_d = StRxHash;
            end
        end
    end

    assign busy_d = state_d != StIdle;
    assign done_d = state_d == StDone;

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            state_q      <= StIdle;
            kk_q         <= '0;
            nn_q         <= '0;
            ll_q         <= '0;
            cfg_idx_q    <= '0;
            byte_cnt_q   <= '0;
            blk_cnt_q    <= '0;
            wait_cnt_q   <= '0;
            data_q       <= '0;
            data_ctrl_q  <= '0;
            loopback_q   <= '0;
            hash_data_q  <= '0;
            hash_valid_q <= 1'b0;
            hash_last_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            kk_q         <= kk_d;
            nn_q         <= nn_d;
            ll_q         <= ll_d;
            cfg_idx_q    <= cfg_idx_d;
            byte_cnt_q   <= byte_cnt_d;
            blk_cnt_q    <= blk_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            data_q       <= data_d;
            data_ctrl_q  <= data_ctrl_d;
            loopback_q   <= loopback_i;
            hash_data_q  <= hash_data_d;
            hash_valid_q <= hash_valid_d;
            hash_last_q  <= hash_last_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    // Handshake for the byte consumed at the coming edge; built only from flop outputs
    // (state, counters, synchronized ready) so it carries no input-to-output path.
    assign msg_ready_o     = (state_q == StData) && ready_s && owed;
    assign data_o          = data_q;
    assign data_ctrl_o     = data_ctrl_q;
    assign loopback_ctrl_o = loopback_q;
    assign hash_data_o     = hash_data_q;
    assign hash_valid_o    = hash_valid_q;
    assign hash_last_o     = hash_last_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign error_o         = error_q;

endmodule

// File: tb/tb_blake2_bus_host.sv
// Directed bench for blake2_bus_host with a small behavioural core model.
module tb_blake2_bus_host;

    logic       clk = 1'b0;
    logic       rst_async;
    logic       start_i;
    logic [7:0] kk_i, nn_i;
    logic [15:0] ll_i;
    logic [7:0] msg_data_i;
    logic       msg_valid_i, msg_ready_o;
    logic [7:0] data_o;
    logic [2:0] data_ctrl_o;
    logic [1:0] loopback_ctrl_o, loopback_i;
    logic [7:0] hash_i, hash_data_o;
    logic [1:0] hash_ctrl_i;
    logic       hash_valid_o, hash_last_o, busy_o, done_o, error_o;

    always #5 clk = ~clk;

    blake2_bus_host #(
        .PMOD_W(8),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk            (clk),
        .rst_async      (rst_async),
        .start_i        (start_i),
        .kk_i           (kk_i),
        .nn_i           (nn_i),
        .ll_i           (ll_i),
        .msg_data_i     (msg_data_i),
        .msg_valid_i    (msg_valid_i),
        .msg_ready_o    (msg_ready_o),
        .data_o         (data_o),
        .data_ctrl_o    (data_ctrl_o),
        .loopback_ctrl_o(loopback_ctrl_o),
        .loopback_i     (loopback_i),
        .hash_i         (hash_i),
        .hash_ctrl_i    (hash_ctrl_i),
        .hash_data_o    (hash_data_o),
        .hash_valid_o   (hash_valid_o),
        .hash_last_o    (hash_last_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .error_o        (error_o)
    );

    int passed = 0;
    int total  = 0;

    logic [7:0] beat_data[$];
    logic [1:0] beat_type[$];
    logic [7:0] hash_q[$];
    logic       hlast_q[$];
    bit         rhist[0:19999];
    int         done_cnt, consumed, ready_bad, err_c, last_beat_c;
    bit         job_timeout, err_at_start;

    // One job, cycle by cycle: inputs driven and outputs sampled 1 time unit after posedge.
    task automatic run_job(input logic [7:0] kk, input logic [7:0] nn, input int ll,
                           input bit toggle_ready, input bit gap, input bit respond,
                           input int abort_at, input bit spurious);
        int c, data_last, hash_start, hsent;
        bit cons, fin, rdy;
        beat_data.delete(); beat_type.delete(); hash_q.delete(); hlast_q.delete();
        done_cnt = 0; consumed = 0; ready_bad = 0; err_c = -1; last_beat_c = -1;
        job_timeout = 1'b0; err_at_start = 1'b1;
        data_last = 0; hash_start = 0; hsent = 0; cons = 1'b0; fin = 1'b0;
        kk_i = kk; nn_i = nn; ll_i = 16'(ll); start_i = 1'b1;
        hash_ctrl_i = 2'b01; hash_i = 8'h00; rhist[0] = 1'b1;
        msg_valid_i = 1'b0; msg_data_i = 8'h00;
        c = 0;
        while (!fin && c < 19990) begin
            @(posedge clk); #1;
            c++;
            if (cons) consumed++;
            if (c == 1) err_at_start = error_o;
            if (data_ctrl_o[0]) begin
                beat_data.push_back(data_o);
                beat_type.push_back(data_ctrl_o[2:1]);
                if (c >= 3 && !rhist[c-3]) ready_bad++;
                if (data_ctrl_o[2:1] == 2'b10) begin
                    data_last++;
                    if (data_last == 64) begin
                        last_beat_c = c;
                        hash_start  = c + 6;
                    end
                end
            end
            if (hash_valid_o) begin
                hash_q.push_back(hash_data_o);
                hlast_q.push_back(hash_last_o);
            end
            if (done_o) done_cnt++;
            if (error_o && err_c < 0) err_c = c;
            if (abort_at > 0 && beat_data.size() == abort_at) return;
            if (c >= 2 && !busy_o) fin = 1'b1;
            // next-cycle stimulus
            start_i = spurious && (c == 40);
            if (spurious && c == 40) begin
                kk_i = 8'hFF;
                ll_i = 16'h1234;
            end
            rdy = toggle_ready ? (((c / 5) % 2) == 0) : 1'b1;
            rhist[c] = rdy;
            hash_ctrl_i[0] = rdy;
            if (respond && c >= 2 && c <= 4) begin
                hash_ctrl_i[1] = 1'b1;  // stray digest beats while configuring
                hash_i = 8'h55;
            end else if (respond && hash_start > 0 && c >= hash_start && hsent < int'(nn)) begin
                hash_ctrl_i[1] = 1'b1;
                hash_i = 8'hC0 + 8'(hsent);
                hsent++;
            end else begin
                hash_ctrl_i[1] = 1'b0;
                hash_i = 8'h00;
            end
            msg_valid_i = (consumed < ll) && !(gap && (c % 3 == 0));
            msg_data_i  = msg_valid_i ? 8'h61 + 8'(consumed) : 8'h00;
            cons = msg_valid_i && msg_ready_o;
        end
        if (!fin) job_timeout = 1'b1;
        start_i = 1'b0; msg_valid_i = 1'b0; hash_ctrl_i = 2'b01; hash_i = 8'h00;
    endtask

    function automatic int bad_cfg(input logic [7:0] kk, input logic [7:0] nn,
                                   input logic [15:0] ll);
        logic [7:0] exp[4];
        int bad;
        exp[0] = kk; exp[1] = nn; exp[2] = ll[7:0]; exp[3] = ll[15:8];
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (i >= beat_data.size()) bad++;
            else if (beat_data[i] !== exp[i] || beat_type[i] !== 2'b00) bad++;
        end
        return bad;
    endfunction

    function automatic int bad_data(input int ll);
        int nblk, bad;
        logic [7:0] exp;
        logic [1:0] et;
        nblk = (ll == 0) ? 1 : (ll + 63) / 64;
        bad = 0;
        for (int i = 0; i < nblk * 64; i++) begin
            if (4 + i >= beat_data.size()) begin
                bad++;
                continue;
            end
            exp = (i < ll) ? 8'h61 + 8'(i) : 8'h00;
            et  = (i / 64 == nblk - 1) ? 2'b10 : 2'b01;
            if (beat_data[4+i] !== exp || beat_type[4+i] !== et) bad++;
        end
        return bad;
    endfunction

    function automatic int bad_hash(input int nn);
        int bad;
        bad = 0;
        for (int k = 0; k < hash_q.size(); k++) begin
            if (hash_q[k] !== 8'hC0 + 8'(k) || hlast_q[k] !== (k == nn - 1)) bad++;
        end
        return bad;
    endfunction

    task automatic test_reset();
        rst_async = 1'b1;
        loopback_i = 2'b11; hash_ctrl_i = 2'b11; hash_i = 8'hFF;
        start_i = 1'b0; msg_valid_i = 1'b1; msg_data_i = 8'hAA;
        kk_i = 8'h00; nn_i = 8'h00; ll_i = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({data_o, data_ctrl_o, loopback_ctrl_o, msg_ready_o, hash_data_o, hash_valid_o,
             hash_last_o, busy_o, done_o, error_o} !== '0)
            $display("FAIL reset_outputs: got data=%h ctrl=%b lb=%b busy=%b err=%b want all 0",
                     data_o, data_ctrl_o, loopback_ctrl_o, busy_o, error_o);
        else passed++;
        rst_async = 1'b0; msg_valid_i = 1'b0; msg_data_i = 8'h00;
        hash_ctrl_i = 2'b01; hash_i = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (busy_o !== 1'b0 || data_ctrl_o !== 3'b000)
            $display("FAIL idle_after_reset: got busy=%b ctrl=%b want 0/000", busy_o, data_ctrl_o);
        else passed++;
    endtask

    task automatic test_loopback();
        total++;
        if (loopback_ctrl_o !== 2'b11)
            $display("FAIL loopback_11: got %b want 11", loopback_ctrl_o);
        else passed++;
        loopback_i = 2'b00;
        @(posedge clk); #1;
        total++;
        if (loopback_ctrl_o !== 2'b00)
            $display("FAIL loopback_00: got %b want 00", loopback_ctrl_o);
        else passed++;
    endtask

    task automatic test_abc();
        run_job(8'd0, 8'd32, 3, 1'b0, 1'b0, 1'b1, 0, 1'b1);
        total++;
        if (job_timeout) $display("FAIL abc_finish: got busy stuck want idle"); else passed++;
        total++;
        if (bad_cfg(8'd0, 8'd32, 16'd3) !== 0)
            $display("FAIL abc_cfg: got %0d bad beats want 0", bad_cfg(8'd0, 8'd32, 16'd3));
        else passed++;
        total++;
        if (beat_data.size() !== 68)
            $display("FAIL abc_beat_count: got %0d want 68", beat_data.size());
        else passed++;
        total++;
        if (bad_data(3) !== 0) $display("FAIL abc_data: got %0d bad want 0", bad_data(3));
        else passed++;
        total++;
        if (consumed !== 3) $display("FAIL abc_consumed: got %0d want 3", consumed); else passed++;
        total++;
        if (hash_q.size() !== 32 || bad_hash(32) !== 0)
            $display("FAIL abc_hash: got %0d bytes %0d bad want 32/0", hash_q.size(), bad_hash(32));
        else passed++;
        total++;
        if (done_cnt !== 1 || error_o !== 1'b0)
            $display("FAIL abc_done: got done=%0d err=%b want 1/0", done_cnt, error_o);
        else passed++;
    endtask

    task automatic test_empty();
        run_job(8'd0, 8'd16, 0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        total++;
        if (beat_data.size() !== 68 || bad_data(0) !== 0 || bad_cfg(8'd0, 8'd16, 16'd0) !== 0)
            $display("FAIL empty_stream: got %0d beats %0d bad want 68/0", beat_data.size(),
                     bad_data(0));
        else passed++;
        total++;
        if (hash_q.size() !== 16 || bad_hash(16) !== 0 || done_cnt !== 1)
            $display("FAIL empty_hash: got %0d bytes done=%0d want 16/1", hash_q.size(), done_cnt);
        else passed++;
    endtask

    task automatic test_multi();
        run_job(8'd0, 8'd8, 130, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        total++;
        if (beat_data.size() !== 196 || bad_data(130) !== 0)
            $display("FAIL multi_stream: got %0d beats %0d bad want 196/0", beat_data.size(),
                     bad_data(130));
        else passed++;
        total++;
        if (consumed !== 130) $display("FAIL multi_consumed: got %0d want 130", consumed);
        else passed++;
        total++;
        if (hash_q.size() !== 8 || bad_hash(8) !== 0 || done_cnt !== 1)
            $display("FAIL multi_hash: got %0d bytes done=%0d want 8/1", hash_q.size(), done_cnt);
        else passed++;
    endtask

    task automatic test_flow();
        run_job(8'd5, 8'd4, 70, 1'b1, 1'b1, 1'b1, 0, 1'b0);
        total++;
        if (ready_bad !== 0)
            $display("FAIL flow_ready_gate: got %0d beats while not ready want 0", ready_bad);
        else passed++;
        total++;
        if (beat_data.size() !== 132 || bad_data(70) !== 0 || bad_cfg(8'd5, 8'd4, 16'd70) !== 0)
            $display("FAIL flow_stream: got %0d beats %0d bad want 132/0", beat_data.size(),
                     bad_data(70));
        else passed++;
        total++;
        if (consumed !== 70 || done_cnt !== 1)
            $display("FAIL flow_consumed: got %0d done=%0d want 70/1", consumed, done_cnt);
        else passed++;
    endtask

    task automatic test_timeout();
        run_job(8'd0, 8'd16, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        total++;
        if (err_c - last_beat_c !== 100)
            $display("FAIL timeout_cycles: got %0d want 100", err_c - last_beat_c);
        else passed++;
        total++;
        if (done_cnt !== 0 || hash_q.size() !== 0)
            $display("FAIL timeout_no_done: got done=%0d hash=%0d want 0/0", done_cnt,
                     hash_q.size());
        else passed++;
        repeat (5) @(posedge clk);
        #1;
        total++;
        if (error_o !== 1'b1 || busy_o !== 1'b0)
            $display("FAIL timeout_sticky: got err=%b busy=%b want 1/0", error_o, busy_o);
        else passed++;
        run_job(8'd1, 8'd4, 3, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        total++;
        if (err_at_start !== 1'b0 || error_o !== 1'b0 || done_cnt !== 1)
            $display("FAIL timeout_clear: got err_start=%b err=%b done=%0d want 0/0/1",
                     err_at_start, error_o, done_cnt);
        else passed++;
    endtask

    task automatic test_reset_mid();
        loopback_i = 2'b01;
        run_job(8'd0, 8'd32, 100, 1'b0, 1'b0, 1'b1, 24, 1'b0);
        #2;
        rst_async = 1'b1;
        #1;
        total++;
        if ({data_o, data_ctrl_o, loopback_ctrl_o, msg_ready_o, hash_data_o, hash_valid_o,
             hash_last_o, busy_o, done_o, error_o} !== '0)
            $display("FAIL reset_mid_outputs: got ctrl=%b rdy=%b lb=%b busy=%b want all 0",
                     data_ctrl_o, msg_ready_o, loopback_ctrl_o, busy_o);
        else passed++;
        start_i = 1'b0; msg_valid_i = 1'b0; hash_ctrl_i = 2'b01; loopback_i = 2'b00;
        @(posedge clk); #1;
        rst_async = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (done_cnt !== 0 || done_o !== 1'b0 || busy_o !== 1'b0)
            $display("FAIL reset_mid_abort: got done=%0d busy=%b want 0/0", done_cnt, busy_o);
        else passed++;
        run_job(8'd0, 8'd32, 100, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        total++;
        if (beat_data.size() !== 132 || bad_data(100) !== 0 || consumed !== 100)
            $display("FAIL reset_mid_rerun: got %0d beats %0d bad %0d consumed want 132/0/100",
                     beat_data.size(), bad_data(100), consumed);
        else passed++;
        total++;
        if (hash_q.size() !== 32 || bad_hash(32) !== 0 || done_cnt !== 1)
            $display("FAIL reset_mid_hash: got %0d bytes done=%0d want 32/1", hash_q.size(),
                     done_cnt);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_abc();
        test_empty();
        test_multi();
        test_flow();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
